dcache_mem_ctrl: RTL

//  Line-fill / write-back engine directly downstream of the data cache. Accepts one miss request
//  (block read or dirty-block write-back) and serialises it onto the byte-wide RAM port.

---
 rtl/dcache_mem_ctrl_pkg.sv | 16 +
 rtl/dcache_line_shifter.sv | 39 +++
 rtl/dcache_mem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dcache_mem_ctrl_pkg.sv
// rtl/dcache_mem_ctrl_pkg.sv - shared line geometry and FSM encodings for the line-fill/write-back engine
// Purpose: constants shared between the data cache and its memory-side engine.
// Ports: none (package).
package dcache_mem_ctrl_pkg;

  // Default line geometry: 16-byte lines.
  localparam int BLOCK_WIDTH_DEF = 4;
  localparam int BLOCK_SIZE_DEF  = 2 ** BLOCK_WIDTH_DEF;

  // Engine FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dcache_line_shifter.sv
// rtl/dcache_line_shifter.sv - N-byte cache line register with byte load, parallel load and byte select
// Purpose: holds the line being filled from RAM or written back to RAM.
// Ports:
//   clk, resetn        clock and synchronous active-low reset
//   load_all, line_in  parallel load of a whole line (has priority over load_byte)
//   load_byte, load_idx, byte_in   write one byte of the line
//   sel_idx, sel_byte  combinational read of one byte
//   line               current line contents
module dcache_line_shifter
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load_all,
  input  logic [BLOCK_SIZE*8-1:0] line_in,
  input  logic                    load_byte,
  input  logic [BLOCK_WIDTH-1:0]  load_idx,
  input  logic [7:0]              byte_in,
  input  logic [BLOCK_WIDTH-1:0]  sel_idx,
  output logic [7:0]              sel_byte,
  output logic [BLOCK_SIZE*8-1:0] line
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      line <= '0;
    end else if (load_all) begin
      line <= line_in;
    end else if (load_byte) begin
      line[load_idx*8 +: 8] <= byte_in;
    end
  end

  assign sel_byte = line[sel_idx*8 +: 8];

endmodule

// File: rtl/dcache_mem_ctrl.sv
// rtl/dcache_mem_ctrl.sv - data-cache line-fill / write-back engine onto a byte-wide RAM port
// Purpose: accepts one miss (line read or dirty-line write-back) and serialises it byte by byte.
// Ports:
//   clkIn, resetIn      clock, synchronous active-low reset
//   miss, missAddr, readWriteIn, writeBackIn   request from the cache (sampled only in IDLE)
//   ramDataIn           RAM read data, valid one cycle after its address
//   ramAddrOut, ramDataOut, ramWriteOut        byte-wide RAM port
//   memDataValid, memDataOut, memAddr          fill completion (1-cycle pulse) and held results
//   acceptWrite         write-back completion (1-cycle pulse)
//   busy                transaction in progress
module dcache_mem_ctrl
  import dcache_mem_ctrl_pkg::*;
#(
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                    clkIn,
  input  logic                    resetIn,
  input  logic                    miss,
  input  logic [31-BLOCK_WIDTH:0] missAddr,
  input  logic                    readWriteIn,
  input  logic [BLOCK_SIZE*8-1:0] writeBackIn,
  input  logic [7:0]              ramDataIn,
  output logic [31:0]             ramAddrOut,
  output logic [7:0]              ramDataOut,
  output logic                    ramWriteOut,
  output logic                    memDataValid,
  output logic [31-BLOCK_WIDTH:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0] memDataOut,
  output logic                    acceptWrite,
  output logic                    busy
);

  localparam int LINE_BITS = BLOCK_SIZE * 8;
  localparam logic [BLOCK_WIDTH:0] K_ONE     = (BLOCK_WIDTH+1)'(1);
  localparam logic [BLOCK_WIDTH:0] K_LAST_RD = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
  localparam logic [BLOCK_WIDTH:0] K_LAST_WR = (BLOCK_WIDTH+1)'(BLOCK_SIZE - 1);

  logic [1:0]              state, state_n;
  logic [BLOCK_WIDTH:0]    k, k_n;
  logic [31-BLOCK_WIDTH:0] addr_q, addr_n;
  logic                    start;
  logic                    addr_phase;
  logic [7:0]              wdata_n;
  logic                    load_byte;
  logic [BLOCK_WIDTH-1:0]  load_idx;
  logic [7:0]              sel_byte;
  logic [LINE_BITS-1:0]    line;
  logic [LINE_BITS-1:0]    line_done;
  logic                    read_last;
  logic                    write_last;

  assign start      = (state == ST_IDLE) && miss;
  assign read_last  = (state == ST_READ) && (k == K_LAST_RD);
  assign write_last = (state == ST_WRITE) && (k == K_LAST_WR);

  always_comb begin
    state_n = state;
    k_n     = k;
    case (state)
      ST_IDLE: begin
        if (miss) begin
          state_n = readWriteIn ? ST_READ : ST_WRITE;
          k_n     = '0;
        end
      end
      ST_READ: begin
        if (k == K_LAST_RD) state_n = ST_DONE;
        else                k_n     = k + K_ONE;
      end
      ST_WRITE: begin
        if (k == K_LAST_WR) state_n = ST_DONE;
        else                k_n     = k + K_ONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered, so the RAM port is driven from the next-cycle
  // state/counter; that makes the address appear in the same cycle as k.
  assign addr_n     = start ? missAddr : addr_q;
  assign addr_phase = ((state_n == ST_READ) && (k_n != K_LAST_RD)) || (state_n == ST_WRITE);

  // The line register is still loading on the start edge, so byte 0 of a
  // write-back comes straight from the request.
  assign wdata_n = start ? writeBackIn[7:0] : sel_byte;

  // RAM data lags its address by one cycle: at count k the byte for k-1 arrives.
  assign load_byte = (state == ST_READ) && (k != '0);
  assign load_idx  = k[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);

  // The last byte lands on the same edge that enters DONE, so fold it in here.
  always_comb begin
    line_done = line;
    line_done[LINE_BITS-8 +: 8] = ramDataIn;
  end

  dcache_line_shifter #(
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_line (
    .clk      (clkIn),
    .resetn   (resetIn),
    .load_all (start),
    .line_in  (writeBackIn),
    .load_byte(load_byte),
    .load_idx (load_idx),
    .byte_in  (ramDataIn),
    .sel_idx  (k_n[BLOCK_WIDTH-1:0]),
    .sel_byte (sel_byte),
    .line     (line)
  );

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state        <= ST_IDLE;
      k            <= '0;
      addr_q       <= '0;
      ramAddrOut   <= '0;
      ramDataOut   <= '0;
      ramWriteOut  <= 1'b0;
      memDataValid <= 1'b0;
      memAddr      <= '0;
      memDataOut   <= '0;
      acceptWrite  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      addr_q       <= addr_n;
      ramAddrOut   <= addr_phase ? {addr_n, k_n[BLOCK_WIDTH-1:0]} : 32'h0;
      ramWriteOut  <= (state_n == ST_WRITE);
      ramDataOut   <= (state_n == ST_WRITE) ? wdata_n : 8'h00;
      memDataValid <= read_last;
      acceptWrite  <= write_last;
      busy         <= (state_n != ST_IDLE);
      if (read_last || write_last) memAddr <= addr_q;
      if (read_last) memDataOut <= line_done;
    end
  end

endmodule
